// File: rtl/step_counter.sv
// Registered up/down step counter with load, wrap/saturate stepping and an
// abortable run-down-to-zero mode, used as a loop/timeout counter.
module step_counter #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              sat_mode,
  input  logic              abort,
  output logic [WIDTH-1:0]  value,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned XW = WIDTH + 1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] run_step;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] cur_step;
  logic [WIDTH-1:0] run_next;
  logic [XW-1:0]    dec_ext;
  logic [XW-1:0]    inc_ext;

  // Datapath: effective step and the three candidate next values.
  // The top bit of dec_ext is the borrow (value < S); of inc_ext the carry.
  always_comb begin
    step_eff = (cmd_step == '0) ? WIDTH'(1) : WIDTH'(cmd_step);
    dec_ext  = {1'b0, value} - {1'b0, step_eff};
    inc_ext  = {1'b0, value} + {1'b0, step_eff};
    cur_step = (state == ST_RUN) ? run_step : step_eff;
    run_next = (value <= cur_step) ? '0 : (value - cur_step);
  end

  assign zero = (value == '0);

  // Control FSM with registered outputs; the acceptance edge of RUN already
  // performs the first decrement, so a run that reaches 0 there never goes busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      value     <= '0;
      run_step  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      ovf  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: value <= cmd_data;
              OP_DEC: begin
                if (dec_ext[WIDTH]) begin
                  value <= sat_mode ? '0 : dec_ext[WIDTH-1:0];
                  ovf   <= 1'b1;
                end else begin
                  value <= dec_ext[WIDTH-1:0];
                end
              end
              OP_INC: begin
                if (inc_ext[WIDTH]) begin
                  value <= sat_mode ? '1 : inc_ext[WIDTH-1:0];
                  ovf   <= 1'b1;
                end else begin
                  value <= inc_ext[WIDTH-1:0];
                end
              end
              OP_RUN: begin
                run_step <= step_eff;
                value    <= run_next;
                if (run_next == '0) begin
                  done <= 1'b1;
                end else begin
                  state     <= ST_RUN;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                end
              end
              default: value <= value;
            endcase
          end
        end
        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            value <= run_next;
            if (run_next == '0) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: stimulus pushes the expected post-edge
// observation per cycle, a monitor pops and compares after each rising edge.
module tb_step_counter;

  localparam int unsigned WIDTH  = 20;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned DRAIN_LIMIT = 20;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             zero;
    logic             busy;
    logic             done;
    logic             ovf;
    logic             ready;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_data;
  logic [STEP_W-1:0] cmd_step;
  logic              sat_mode;
  logic              abort;
  logic [WIDTH-1:0]  value;
  logic              zero;
  logic              busy;
  logic              done;
  logic              ovf;

  obs_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_step(cmd_step),
    .sat_mode(sat_mode), .abort(abort), .value(value), .zero(zero),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Monitor: one expected observation per cycle, checked just after the edge.
  always @(posedge clk) begin
    obs_t  e;
    obs_t  a;
    string nm;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{value: value, zero: zero, busy: busy, done: done, ovf: ovf, ready: cmd_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got value=%h zero=%b busy=%b done=%b ovf=%b ready=%b, expected value=%h zero=%b busy=%b done=%b ovf=%b ready=%b",
                 nm, a.value, a.zero, a.busy, a.done, a.ovf, a.ready,
                 e.value, e.zero, e.busy, e.done, e.ovf, e.ready);
      end
    end
  end

  // Direct comparison of all outputs against the reset state.
  task automatic expect_reset_state(input string nm);
    @(posedge clk);
    #2;
    checks++;
    if (value !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        ovf !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: reset state wrong value=%h zero=%b busy=%b done=%b ovf=%b ready=%b",
               nm, value, zero, busy, done, ovf, cmd_ready);
    end
  endtask

  // Drive one cycle of inputs and queue what must be visible after the next edge.
  task automatic cyc(input logic rn, input logic v, input logic [1:0] op,
                     input logic [WIDTH-1:0] d, input logic [STEP_W-1:0] s,
                     input logic sm, input logic ab, input logic [WIDTH-1:0] ev,
                     input logic eb, input logic ed, input logic eo,
                     input logic er, input string nm);
    obs_t e;
    @(negedge clk);
    rst_n = rn; cmd_valid = v; cmd_op = op; cmd_data = d;
    cmd_step = s; sat_mode = sm; abort = ab;
    e = '{value: ev, zero: (ev == '0), busy: eb, done: ed, ovf: eo, ready: er};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] d,
                     input logic [STEP_W-1:0] s, input logic sm,
                     input logic [WIDTH-1:0] ev, input logic eo, input string nm);
    cyc(1'b1, 1'b1, op, d, s, sm, 1'b0, ev, 1'b0, 1'b0, eo, 1'b1, nm);
  endtask

  task automatic idle(input logic ab, input logic [WIDTH-1:0] ev, input logic eb,
                      input logic ed, input logic er, input string nm);
    cyc(1'b1, 1'b0, OP_LOAD, '0, '0, 1'b0, ab, ev, eb, ed, 1'b0, er, nm);
  endtask

  initial begin
    logic [WIDTH-1:0] mv;
    logic [WIDTH-1:0] nv;
    logic [WIDTH-1:0] rd;
    logic [1:0]       rop;
    logic [STEP_W-1:0] rs;
    logic             rsm;
    logic             eo;
    longint           s;
    longint           sum;
    int               waited;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_data = '0;
    cmd_step = '0; sat_mode = 1'b0; abort = 1'b0;

    cyc(1'b0, 1'b0, OP_LOAD, '0, '0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    cyc(1'b0, 1'b1, OP_LOAD, 20'h12345, '0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_ignores_cmd");
    expect_reset_state("reset_state_direct");

    // Wrap-mode DEC walk through zero.
    cmd(OP_LOAD, 20'h00005, 4'd0, 1'b0, 20'h00005, 1'b0, "load5");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'h00004, 1'b0, "dec_4");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'h00003, 1'b0, "dec_3");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'h00002, 1'b0, "dec_2");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'h00001, 1'b0, "dec_1");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'h00000, 1'b0, "dec_0_no_ovf");
    cmd(OP_DEC,  20'h0, 4'd1, 1'b0, 20'hFFFFF, 1'b1, "dec_wrap_ovf");
    idle(1'b0, 20'hFFFFF, 1'b0, 1'b0, 1'b1, "hold_after_wrap");

    // Saturate and wrap boundaries.
    cmd(OP_LOAD, 20'h00003, 4'd0, 1'b1, 20'h00003, 1'b0, "load3");
    cmd(OP_DEC,  20'h0, 4'd5, 1'b1, 20'h00000, 1'b1, "dec_sat_clamp");
    cmd(OP_LOAD, 20'hFFFFE, 4'd0, 1'b1, 20'hFFFFE, 1'b0, "loadFFFFE");
    cmd(OP_INC,  20'h0, 4'd4, 1'b1, 20'hFFFFF, 1'b1, "inc_sat_clamp");
    cmd(OP_LOAD, 20'hFFFFE, 4'd0, 1'b1, 20'hFFFFE, 1'b0, "loadFFFFE_b");
    cmd(OP_INC,  20'h0, 4'd0, 1'b1, 20'hFFFFF, 1'b0, "inc_step0_to_max");
    cmd(OP_LOAD, 20'hFFFFE, 4'd0, 1'b0, 20'hFFFFE, 1'b0, "loadFFFFE_c");
    cmd(OP_INC,  20'h0, 4'd4, 1'b0, 20'h00002, 1'b1, "inc_wrap_carry");
    cmd(OP_LOAD, 20'hFFFFC, 4'd0, 1'b0, 20'hFFFFC, 1'b0, "loadFFFFC");
    cmd(OP_INC,  20'h0, 4'd3, 1'b0, 20'hFFFFF, 1'b0, "inc_exact_max");
    cmd(OP_DEC,  20'h0, 4'd15, 1'b1, 20'hFFFF0, 1'b0, "dec_step15");

    // RUN from 10 by 3, with a command held valid while busy.
    cmd(OP_LOAD, 20'd10, 4'd0, 1'b0, 20'd10, 1'b0, "load10");
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd3, 1'b0, 1'b0, 20'd7, 1'b1, 1'b0, 1'b0, 1'b0, "run_7");
    cyc(1'b1, 1'b1, OP_LOAD, 20'd123, 4'd0, 1'b0, 1'b0, 20'd4, 1'b1, 1'b0, 1'b0, 1'b0, "run_4_cmd_blocked");
    cyc(1'b1, 1'b1, OP_LOAD, 20'd123, 4'd0, 1'b0, 1'b0, 20'd1, 1'b1, 1'b0, 1'b0, 1'b0, "run_1_cmd_blocked");
    cyc(1'b1, 1'b1, OP_LOAD, 20'd123, 4'd0, 1'b1, 1'b0, 20'd0, 1'b0, 1'b1, 1'b0, 1'b1, "run_done");
    idle(1'b0, 20'd0, 1'b0, 1'b0, 1'b1, "done_one_cycle");

    // RUN from zero, and RUN that reaches zero on the acceptance edge.
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd1, 1'b0, 1'b0, 20'd0, 1'b0, 1'b1, 1'b0, 1'b1, "run_from_zero");
    idle(1'b0, 20'd0, 1'b0, 1'b0, 1'b1, "run_zero_after");
    cmd(OP_LOAD, 20'd2, 4'd0, 1'b0, 20'd2, 1'b0, "load2");
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd5, 1'b1, 1'b0, 20'd0, 1'b0, 1'b1, 1'b0, 1'b1, "run_le_step");

    // Abort mid-run, then abort ignored in IDLE.
    cmd(OP_LOAD, 20'd100, 4'd0, 1'b0, 20'd100, 1'b0, "load100");
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd1, 1'b0, 1'b0, 20'd99, 1'b1, 1'b0, 1'b0, 1'b0, "run_99");
    idle(1'b0, 20'd98, 1'b1, 1'b0, 1'b0, "run_98");
    idle(1'b0, 20'd97, 1'b1, 1'b0, 1'b0, "run_97");
    idle(1'b0, 20'd96, 1'b1, 1'b0, 1'b0, "run_96");
    idle(1'b1, 20'd96, 1'b0, 1'b0, 1'b1, "abort_hold_96");
    idle(1'b0, 20'd96, 1'b0, 1'b0, 1'b1, "idle_after_abort");
    cyc(1'b1, 1'b1, OP_DEC, '0, 4'd1, 1'b0, 1'b1, 20'd95, 1'b0, 1'b0, 1'b0, 1'b1, "dec_after_abort");

    // Abort on the edge that would write zero.
    cmd(OP_LOAD, 20'd2, 4'd0, 1'b0, 20'd2, 1'b0, "load2_b");
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd1, 1'b0, 1'b0, 20'd1, 1'b1, 1'b0, 1'b0, 1'b0, "run_1");
    idle(1'b1, 20'd1, 1'b0, 1'b0, 1'b1, "abort_beats_zero");
    idle(1'b0, 20'd1, 1'b0, 1'b0, 1'b1, "no_late_done");

    // Reset mid-run.
    cmd(OP_LOAD, 20'd50, 4'd0, 1'b0, 20'd50, 1'b0, "load50");
    cyc(1'b1, 1'b1, OP_RUN, '0, 4'd2, 1'b0, 1'b0, 20'd48, 1'b1, 1'b0, 1'b0, 1'b0, "run_48");
    idle(1'b0, 20'd46, 1'b1, 1'b0, 1'b0, "run_46");
    cyc(1'b0, 1'b0, OP_LOAD, '0, '0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_mid_run");
    expect_reset_state("reset_mid_run_direct");
    cyc(1'b0, 1'b0, OP_LOAD, '0, '0, 1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_held");
    idle(1'b0, 20'd0, 1'b0, 1'b0, 1'b1, "after_reset_no_done");

    // Random LOAD/DEC/INC stream against an arithmetic reference model.
    mv = '0;
    for (int i = 0; i < 1000; i++) begin
      rop = 2'($urandom_range(0, 2));
      rd  = 20'($urandom);
      rs  = 4'($urandom_range(0, 15));
      rsm = 1'($urandom_range(0, 1));
      s   = (rs == 0) ? 64'd1 : longint'(rs);
      eo  = 1'b0;
      if (rop == OP_LOAD) begin
        nv = rd;
      end else if (rop == OP_DEC) begin
        if (longint'(mv) < s) begin
          eo = 1'b1;
          nv = rsm ? 20'd0 : 20'(longint'(mv) + 64'h100000 - s);
        end else begin
          nv = 20'(longint'(mv) - s);
        end
      end else begin
        sum = longint'(mv) + s;
        if (sum > 64'hFFFFF) begin
          eo = 1'b1;
          nv = rsm ? 20'hFFFFF : 20'(sum - 64'h100000);
        end else begin
          nv = 20'(sum);
        end
      end
      cmd(rop, rd, rs, rsm, nv, eo, "random_cmd");
      mv = nv;
    end
    idle(1'b0, mv, 1'b0, 1'b0, 1'b1, "random_final_hold");

    // Bounded wait for the scoreboard to drain.
    waited = 0;
    while (exp_q.size() != 0 && waited < DRAIN_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected observations still pending after %0d cycles",
               exp_q.size(), waited);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
